// File: rtl/jump_ctrl_pkg.sv
// Shared types and defaults for the Execute-stage PC controller.
// Imported by jump_ctrl and jump_target.
package jump_ctrl_pkg;

   typedef enum logic {
      JC_RUN   = 1'b0,
      JC_FLUSH = 1'b1
   } jc_state_e;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;
   localparam int          FLUSH_DEPTH_DEFAULT = 2;
   localparam int          CNT_W = 3;

   // Without the C extension every target must be word aligned.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/jump_target.sv
// Jump target adder with JALR bit-0 mask and alignment check.
// Purely combinational; feeds the jump_ctrl FSM.
module jump_target
   import jump_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            is_jalr,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] imm_de,
   input  logic [XLEN-1:0] rs1data_de,
   output logic [XLEN-1:0] target,
   output logic            misaligned
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;

   always_comb begin
      base = is_jalr ? rs1data_de : pc_ex;
      sum  = base + imm_de;
      // JALR drops bit 0 before the alignment check, so only bit 1 can trap.
      target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
      misaligned = is_misaligned(target[1:0]);
   end

endmodule

// File: rtl/jump_ctrl.sv
// Execute-stage PC controller: resolves jumps, owns the fetch PC,
// and drives redirect / squash / misaligned-target trap signalling.
module jump_ctrl
   import jump_ctrl_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] PC_RESET    = PC_RESET_DEFAULT,
   parameter logic [XLEN-1:0] TRAP_VEC    = TRAP_VEC_DEFAULT,
   parameter int              FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            fetch_adv,
   input  logic            ex_valid,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic            jump_state_pre,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] imm_de,
   input  logic [XLEN-1:0] rs1data_de,
   output logic [XLEN-1:0] pc,
   output logic            redirect,
   output logic            squash,
   output logic [XLEN-1:0] link_data,
   output logic            misalign_trap,
   output logic [XLEN-1:0] trap_epc,
   output logic [XLEN-1:0] trap_tval
);

   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FLUSH_DEPTH);
   localparam logic [XLEN-1:0]  STEP  = XLEN'(4);

   jc_state_e        state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  target;
   logic             tgt_mis;
   logic             br_true;
   logic             taken;

   jump_target #(
      .XLEN(XLEN)
   ) u_target (
      .is_jalr   (is_jalr),
      .pc_ex     (pc_ex),
      .imm_de    (imm_de),
      .rs1data_de(rs1data_de),
      .target    (target),
      .misaligned(tgt_mis)
   );

   // The comparator may emit X for non-branch funct3; keep it out.
   always_comb begin
      br_true = is_branch ? jump_state_pre : 1'b0;
      taken   = ex_valid & ~squash & (is_jal | is_jalr | br_true);
   end

   assign link_data = pc_ex + STEP;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= JC_RUN;
         cnt           <= '0;
         pc            <= PC_RESET;
         redirect      <= 1'b0;
         squash        <= 1'b0;
         misalign_trap <= 1'b0;
         trap_epc      <= '0;
         trap_tval     <= '0;
      end else if (stall) begin
         redirect      <= 1'b0;
         misalign_trap <= 1'b0;
      end else begin
         redirect      <= 1'b0;
         misalign_trap <= 1'b0;
         unique case (state)
            JC_RUN: begin
               if (taken && tgt_mis) begin
                  pc            <= TRAP_VEC;
                  redirect      <= 1'b1;
                  misalign_trap <= 1'b1;
                  trap_epc      <= pc_ex;
                  trap_tval     <= target;
                  squash        <= 1'b1;
                  cnt           <= DEPTH;
                  state         <= JC_FLUSH;
               end else if (taken) begin
                  pc       <= target;
                  redirect <= 1'b1;
                  squash   <= 1'b1;
                  cnt      <= DEPTH;
                  state    <= JC_FLUSH;
               end else if (fetch_adv) begin
                  pc <= pc + STEP;
               end
            end
            JC_FLUSH: begin
               if (fetch_adv) begin
                  pc <= pc + STEP;
               end
               // Squash covers FLUSH_DEPTH unstalled cycles in total.
               if (cnt <= CNT_W'(1)) begin
                  cnt    <= '0;
                  squash <= 1'b0;
                  state  <= JC_RUN;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               squash <= 1'b0;
               cnt    <= '0;
               state  <= JC_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: directed vectors push expected
// registered outputs; a negedge monitor pops and compares.
module tb_jump_ctrl;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        fetch_adv;
   logic        ex_valid;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic        jump_state_pre;
   logic [31:0] pc_ex;
   logic [31:0] imm_de;
   logic [31:0] rs1data_de;
   logic [31:0] pc;
   logic        redirect;
   logic        squash;
   logic [31:0] link_data;
   logic        misalign_trap;
   logic [31:0] trap_epc;
   logic [31:0] trap_tval;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        rd;
      logic        sq;
      logic        tp;
      logic [31:0] epc;
      logic [31:0] tval;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   jump_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .fetch_adv     (fetch_adv),
      .ex_valid      (ex_valid),
      .is_branch     (is_branch),
      .is_jal        (is_jal),
      .is_jalr       (is_jalr),
      .jump_state_pre(jump_state_pre),
      .pc_ex         (pc_ex),
      .imm_de        (imm_de),
      .rs1data_de    (rs1data_de),
      .pc            (pc),
      .redirect      (redirect),
      .squash        (squash),
      .link_data     (link_data),
      .misalign_trap (misalign_trap),
      .trap_epc      (trap_epc),
      .trap_tval     (trap_tval)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            if (pc !== e.pc || redirect !== e.rd || squash !== e.sq ||
                misalign_trap !== e.tp || trap_epc !== e.epc ||
                trap_tval !== e.tval) begin
               fails++;
               $display("FAIL %s: got pc=%h rd=%b sq=%b tp=%b epc=%h tval=%h want pc=%h rd=%b sq=%b tp=%b epc=%h tval=%h",
                        e.name, pc, redirect, squash, misalign_trap,
                        trap_epc, trap_tval, e.pc, e.rd, e.sq, e.tp,
                        e.epc, e.tval);
            end
         end
      end
   end

   task automatic drv(input logic st, input logic fa, input logic ev,
                      input logic br, input logic jl, input logic jr,
                      input logic jsp, input logic [31:0] pe,
                      input logic [31:0] im, input logic [31:0] r1);
      stall          = st;
      fetch_adv      = fa;
      ex_valid       = ev;
      is_branch      = br;
      is_jal         = jl;
      is_jalr        = jr;
      jump_state_pre = jsp;
      pc_ex          = pe;
      imm_de         = im;
      rs1data_de     = r1;
   endtask

   task automatic idle(input logic fa);
      drv(1'b0, fa, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic step(input string nm, input logic [31:0] p,
                       input logic rd, input logic sq, input logic tp,
                       input logic [31:0] ep, input logic [31:0] tv);
      exp_t e;
      e.name = nm;
      e.pc   = p;
      e.rd   = rd;
      e.sq   = sq;
      e.tp   = tp;
      e.epc  = ep;
      e.tval = tv;
      @(posedge clk);
      sbq.push_back(e);
      #1;
   endtask

   task automatic chk_link(input string nm, input logic [31:0] want);
      #1;
      tests++;
      if (link_data !== want) begin
         fails++;
         $display("FAIL %s: got link=%h want %h", nm, link_data, want);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle(1'b0);
      step("reset0", 32'h0, 0, 0, 0, 32'h0, 32'h0);
      step("reset1", 32'h0, 0, 0, 0, 32'h0, 32'h0);
      rst = 1'b0;

      idle(1'b1);
      step("seq4", 32'h4, 0, 0, 0, 32'h0, 32'h0);
      step("seq8", 32'h8, 0, 0, 0, 32'h0, 32'h0);
      step("seq12", 32'hC, 0, 0, 0, 32'h0, 32'h0);

      // BEQ taken with fetch_adv high: redirect wins.
      drv(0, 1, 1, 1, 0, 0, 1, 32'h40, 32'h20, 32'h0);
      step("beq_taken", 32'h60, 1, 1, 0, 32'h0, 32'h0);
      drv(0, 0, 1, 1, 0, 0, 1, 32'h80, 32'h40, 32'h0);
      step("beq_in_squash", 32'h60, 0, 1, 0, 32'h0, 32'h0);
      idle(1'b0);
      step("squash_end", 32'h60, 0, 0, 0, 32'h0, 32'h0);

      drv(0, 1, 1, 1, 0, 0, 0, 32'h60, 32'h100, 32'h0);
      step("br_not_taken", 32'h64, 0, 0, 0, 32'h0, 32'h0);
      drv(0, 1, 1, 0, 0, 0, 1'bx, 32'h64, 32'h100, 32'h0);
      step("nonjump_x", 32'h68, 0, 0, 0, 32'h0, 32'h0);

      drv(0, 0, 1, 0, 0, 1, 0, 32'h68, 32'h2, 32'h101);
      chk_link("link_jalr_mis", 32'h6C);
      step("jalr_trap", 32'h100, 1, 1, 1, 32'h68, 32'h102);
      idle(1'b0);
      step("trap_sq2", 32'h100, 0, 1, 0, 32'h68, 32'h102);
      step("trap_sq_end", 32'h100, 0, 0, 0, 32'h68, 32'h102);

      drv(0, 0, 1, 0, 0, 1, 0, 32'h100, 32'h0, 32'h201);
      chk_link("link_jalr_ok", 32'h104);
      step("jalr_mask", 32'h200, 1, 1, 0, 32'h68, 32'h102);
      idle(1'b1);
      step("flush_adv", 32'h204, 0, 1, 0, 32'h68, 32'h102);
      step("flush_adv_end", 32'h208, 0, 0, 0, 32'h68, 32'h102);

      drv(1, 1, 1, 0, 1, 0, 0, 32'h208, 32'h10, 32'h0);
      step("stall_a", 32'h208, 0, 0, 0, 32'h68, 32'h102);
      step("stall_b", 32'h208, 0, 0, 0, 32'h68, 32'h102);
      step("stall_c", 32'h208, 0, 0, 0, 32'h68, 32'h102);
      stall = 1'b0;
      step("jal_after_stall", 32'h218, 1, 1, 0, 32'h68, 32'h102);
      drv(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      step("stall_in_flush", 32'h218, 0, 1, 0, 32'h68, 32'h102);
      idle(1'b0);
      step("flush_ext", 32'h218, 0, 1, 0, 32'h68, 32'h102);
      step("flush_ext_end", 32'h218, 0, 0, 0, 32'h68, 32'h102);

      drv(0, 0, 1, 0, 1, 0, 0, 32'h218, 32'h6, 32'h0);
      step("jal_trap", 32'h100, 1, 1, 1, 32'h218, 32'h21E);
      idle(1'b0);
      step("jal_trap_sq", 32'h100, 0, 1, 0, 32'h218, 32'h21E);
      step("jal_trap_end", 32'h100, 0, 0, 0, 32'h218, 32'h21E);

      drv(0, 0, 1, 1, 0, 0, 1, 32'h100, 32'h1000, 32'h0);
      step("beq_far", 32'h1100, 1, 1, 0, 32'h218, 32'h21E);
      idle(1'b1);
      rst = 1'b1;
      step("rst_in_flush", 32'h0, 0, 0, 0, 32'h0, 32'h0);
      rst = 1'b0;
      drv(0, 0, 1, 1, 0, 0, 1, 32'h4, 32'h8, 32'h0);
      step("run_after_rst", 32'hC, 1, 1, 0, 32'h0, 32'h0);
      idle(1'b0);
      step("wrap_sq", 32'hC, 0, 1, 0, 32'h0, 32'h0);
      step("wrap_sq_end", 32'hC, 0, 0, 0, 32'h0, 32'h0);
      drv(0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20, 32'h0);
      step("jal_wrap", 32'h10, 1, 1, 0, 32'h0, 32'h0);
      idle(1'b0);

      @(negedge clk);
      #1;
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Execute-stage program-counter controller for the RockWave core. It consumes the branch comparison result (`jump_state_pre`) and the decoded jump class of the instruction in Execute, and resolves taken/not-taken. It then owns the fetch PC register and issues redirect, squash and misaligned-target trap signalling to Fetch/Decode. It sits directly downstream of the branch comparator and upstream of Fetch and the CSR/trap logic.

## Interface
- `XLEN`, 32, data/address width
- `PC_RESET`, 32'h0000_0000, fetch PC after reset
- `TRAP_VEC`, 32'h0000_0100, fetch PC on misaligned-target trap
- `FLUSH_DEPTH`, 2, cycles of squash after a redirect (1..7)
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  global pipeline stall; freezes all state
- `fetch_adv`  in  1  Fetch consumed current `pc`; advance sequentially
- `ex_valid`  in  1  Execute holds a valid instruction this cycle
- `is_branch` / `is_jal` / `is_jalr`  in  1 each  decoded jump class, one-hot or all zero
- `jump_state_pre`  in  1  comparator result (1 = condition true)
- `pc_ex`  in  XLEN  PC of the instruction in Execute
- `imm_de`  in  XLEN  sign-extended immediate
- `rs1data_de`  in  XLEN  rs1 operand (for JALR)
- `pc`  out  XLEN  registered fetch PC
- `redirect`  out  1  one-cycle pulse: `pc` was loaded non-sequentially
- `squash`  out  1  Fetch/Decode contents invalid; kill them
- `link_data`  out  XLEN  `pc_ex + 4`, combinational, for rd write of JAL/JALR
- `misalign_trap`  out  1  one-cycle pulse: taken target not 4-byte aligned
- `trap_epc` / `trap_tval`  out  XLEN  faulting `pc_ex` / faulting target, registered

## Operation
- `taken = ex_valid & ~squash & (is_jal | is_jalr | (is_branch & jump_state_pre))`.
- Target: branch/JAL `pc_ex + imm_de`; JALR `(rs1data_de + imm_de) & ~1`. All sums are mod 2^XLEN; wrap-around is silently discarded.
- No C extension: `target[1:0] != 0` on a taken jump raises a trap. A JALR with `target[0]` set alone is cleared by the mask, so it does not trap.
- States: RUN, FLUSH.
  - RUN, taken & aligned: `pc <= target`, `redirect` pulse, counter <= FLUSH_DEPTH, go to FLUSH.
  - RUN, taken & misaligned: `pc <= TRAP_VEC`, `misalign_trap` and `redirect` pulse, `trap_epc <= pc_ex`, `trap_tval <= target`, go to FLUSH.
  - RUN, not taken: `pc <= pc + 4` if `fetch_adv`, else hold.
  - FLUSH: `squash = 1`. Counter decrements each unstalled cycle and the state returns to RUN when the counter reaches 1. `fetch_adv` advances `pc`. `ex_valid` is ignored, so no new redirect can occur.
- Priority: `rst` > `stall` > trap > redirect > sequential advance.
- `stall` = 1 holds `pc`, state, counter and trap registers, and suppresses pulse outputs.
- Condition-false branch and non-jump instructions take no action beyond sequential advance.
- `jump_state_pre` is used only when `is_branch` = 1. Its X on unknown funct3 must not propagate when `is_branch` = 0; gate it.

## Timing
- Reset values: `pc` = PC_RESET, state RUN, counter 0, `redirect` = `squash` = `misalign_trap` = 0, `trap_epc` = `trap_tval` = 0.
- Resolution latency: taken in cycle N gives the new `pc` visible in N+1. `redirect`/`misalign_trap` are high in N+1 only. `squash` is high in N+1 … N+FLUSH_DEPTH.
- `link_data` is valid in the same cycle as `pc_ex`; it has no register.
- Redirect while `fetch_adv` = 1: the redirect wins and the +4 is dropped.
- `rst` asserted mid-FLUSH: next cycle is the reset state; the squash ends immediately.
- `stall` during FLUSH extends the squash window by the stalled cycles.

## Structure
- Add state encodings (`JC_RUN`, `JC_FLUSH`) and `TRAP_VEC` default to `core_general.vh`, next to the existing FUNCT3 constants.
- One sub-module, `jump_target`: combinational target adder and JALR mask plus misalignment detect. The FSM, PC register and counter stay in `jump_ctrl`.

## Test plan
- Reset, then `fetch_adv` = 1 for 3 cycles -> `pc` = 0, 4, 8, 12; no pulses.
- BEQ taken: `pc_ex` = 0x40, `imm_de` = 0x20, `jump_state_pre` = 1 -> next `pc` = 0x60, `redirect` for 1 cycle, `squash` for 2 cycles. A second taken branch during squash is ignored.
- JALR: `rs1data_de` = 0x101, `imm_de` = 0x2 -> target 0x102 is misaligned, so `pc` = 0x100 (TRAP_VEC), `trap_epc` = `pc_ex`, `trap_tval` = 0x102. Separately, `rs1data_de` = 0x201, `imm_de` = 0 -> target 0x200, no trap, `link_data` = `pc_ex` + 4.
- Branch not taken: `jump_state_pre` = 0 with `fetch_adv` = 1 -> `pc` += 4, no `redirect`. `is_branch` = 0 with `jump_state_pre` = X -> no X on any output.
- `stall` = 1 in the taken cycle for 3 cycles -> `pc` unchanged and no pulse until the stall drops, then the redirect occurs.
- `rst` asserted in the second squash cycle -> next cycle `pc` = PC_RESET, `squash` = 0, state RUN.
